mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter: MemSize encoding,
// FSM state type, transaction-owner constants and the alignment predicate.
package mem_arb_pkg;

  localparam logic [1:0] MS_BYTE = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_WORD = 2'b11;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RSP  = 2'b10
  } arb_state_e;

  // True when a half is not 2-byte aligned or a word is not 4-byte aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == MS_HALF) && lo[0]) || ((size == MS_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store mask/replication from the requester's
// size and address, load lane selection with sign or zero extension.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_wdata_i,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lo_i,
  input  logic        ld_uns_i,
  input  logic [31:0] ld_rdata_i,
  output logic [3:0]  st_wmask_o,
  output logic [31:0] st_wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wmask_o = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      MS_BYTE: begin
        st_wmask_o = 4'b0001 << st_lo_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      MS_HALF: begin
        st_wmask_o = st_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: begin
        st_wmask_o = 4'b1111;
        st_wdata_o = st_wdata_i;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata_i[7:0];
    case (ld_lo_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
  end

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_size_i)
      MS_BYTE: ld_data_o = {{24{ld_byte[7] & ~ld_uns_i}}, ld_byte};
      MS_HALF: ld_data_o = {{16{ld_half[15] & ~ld_uns_i}}, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time. Define MEM_ARB_ALIGN_CHECK_EN to reject misaligned data accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic              dm_unsigned,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("mem_port_arbiter: DATA_W must be 32");
    end
  endgenerate

  arb_state_e        state_q;
  logic              own_q;
  logic              last_own_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [1:0]        lo_q;
  logic              uns_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_wmask_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              dm_win_d;
  logic              if_win_d;
  logic              dm_bad_d;
  logic [3:0]        st_wmask;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;
  logic              rsp_fire;
  logic              wr_fire;
  logic              dm_rsp;
  logic              unused_if_lo;

  assign unused_if_lo = ^if_addr[1:0];

  mem_lane_align u_align (
    .st_size_i  (dm_size),
    .st_lo_i    (dm_addr[1:0]),
    .st_wdata_i (dm_wdata),
    .ld_size_i  (size_q),
    .ld_lo_i    (lo_q),
    .ld_uns_i   (uns_q),
    .ld_rdata_i (mem_rdata),
    .st_wmask_o (st_wmask),
    .st_wdata_o (st_wdata),
    .ld_data_o  (ld_data)
  );

  // Data side wins a tie unless it also took the previous grant.
  assign dm_win_d = dm_req && (!if_req || (last_own_q != OWN_DM));
  assign if_win_d = if_req && !dm_win_d;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign dm_bad_d = dm_win_d && misaligned(dm_size, dm_addr[1:0]);
`else
  assign dm_bad_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_q       <= OWN_IF;
      last_own_q  <= OWN_IF;
      err_q       <= 1'b0;
      size_q      <= MS_WORD;
      lo_q        <= 2'b00;
      uns_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= 4'b0000;
      mem_wdata_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // While an error pulse is out the requester still holds dm_req; skip it.
          if (!err_q && (dm_win_d || if_win_d)) begin
            if (dm_bad_d) begin
              err_q      <= 1'b1;
              last_own_q <= OWN_DM;
            end else if (dm_win_d) begin
              state_q     <= REQ;
              own_q       <= OWN_DM;
              last_own_q  <= OWN_DM;
              mem_req_q   <= 1'b1;
              mem_we_q    <= dm_we;
              mem_addr_q  <= {dm_addr[ADDR_W-1:2], 2'b00};
              mem_wmask_q <= st_wmask;
              mem_wdata_q <= st_wdata;
              size_q      <= dm_size;
              lo_q        <= dm_addr[1:0];
              uns_q       <= dm_unsigned;
            end else begin
              state_q     <= REQ;
              own_q       <= OWN_IF;
              last_own_q  <= OWN_IF;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {if_addr[ADDR_W-1:2], 2'b00};
              mem_wmask_q <= 4'b1111;
              mem_wdata_q <= '0;
              size_q      <= MS_WORD;
              lo_q        <= 2'b00;
              uns_q       <= 1'b0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_we_q ? IDLE : RSP;
          end
        end
        RSP: begin
          if (mem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_fire = (state_q == RSP) && mem_rvalid;
  assign wr_fire  = (state_q == REQ) && mem_gnt && mem_we_q;
  assign dm_rsp   = rsp_fire && (own_q == OWN_DM);

  assign if_valid = rsp_fire && (own_q == OWN_IF);
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign dm_valid = dm_rsp || wr_fire || err_q;
  assign dm_rdata = dm_rsp ? ld_data : '0;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign dm_err = err_q;
`else
  assign dm_err = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the memory side is
// driven cycle-by-cycle from each scenario task.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [1:0]  dm_size = 2'b00;
  logic        dm_unsigned = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .dm_err(dm_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full data read with gnt one cycle after the request is seen and rvalid one after that.
  task automatic dm_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] rd, output logic [31:0] maddr, output logic v,
                         output logic [31:0] data, output logic err);
    dm_req = 1'b1; dm_we = 1'b0; dm_size = size; dm_unsigned = uns; dm_addr = addr;
    @(posedge clk); #1;
    maddr = mem_addr;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    #1;
    v = dm_valid; data = dm_rdata; err = dm_err;
    @(posedge clk); #1;
    dm_req = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_chk++; if (mem_wmask !== 4'b0000) begin n_fail++; $display("FAIL reset_mem_wmask: got %b want 0000", mem_wmask); end
    n_chk++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr_data: got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_chk++; if ({if_valid, dm_valid, dm_err} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b want 000", {if_valid, dm_valid, dm_err}); end
    n_chk++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lone_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    @(posedge clk); #1;
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_req: got %b want 1", mem_req); end
    n_chk++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_mem_addr: got %h want 00000100", mem_addr); end
    n_chk++; if (mem_we !== 1'b0 || mem_wmask !== 4'b1111) begin n_fail++; $display("FAIL fetch_we_mask: got %b/%b want 0/1111", mem_we, mem_wmask); end
    // rvalid together with gnt must be ignored
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
    #1;
    n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_rvalid_in_req: if_valid got %b want 0", if_valid); end
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_drop: got %b want 0", mem_req); end
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_chk++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_if_valid: got %b want 1", if_valid); end
    n_chk++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_if_rdata: got %h want deadbeef", if_rdata); end
    n_chk++; if (dm_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_dm_valid: got %b want 0", dm_valid); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0; if_req = 1'b0;
    #1;
    n_chk++; if (if_valid !== 1'b0 || if_rdata !== 32'h0) begin n_fail++; $display("FAIL fetch_after: got %b/%h want 0/0", if_valid, if_rdata); end
  endtask

  task automatic test_store();
    logic [3:0]  exp_mask [2];
    logic [31:0] exp_data [2];
    logic [31:0] addrs [2];
    logic [31:0] wds [2];
    logic [1:0]  szs [2];
    addrs[0] = 32'h203; wds[0] = 32'h000000A5; szs[0] = MS_BYTE; exp_mask[0] = 4'b1000; exp_data[0] = 32'hA5A5A5A5;
    addrs[1] = 32'h012; wds[1] = 32'h00001234; szs[1] = MS_HALF; exp_mask[1] = 4'b1100; exp_data[1] = 32'h12341234;
    for (int i = 0; i < 2; i++) begin
      dm_req = 1'b1; dm_we = 1'b1; dm_size = szs[i]; dm_addr = addrs[i]; dm_wdata = wds[i];
      @(posedge clk); #1;
      n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL store%0d_req_we: got %b/%b want 1/1", i, mem_req, mem_we); end
      n_chk++; if (mem_addr !== {addrs[i][31:2], 2'b00}) begin n_fail++; $display("FAIL store%0d_addr: got %h want %h", i, mem_addr, {addrs[i][31:2], 2'b00}); end
      n_chk++; if (mem_wmask !== exp_mask[i]) begin n_fail++; $display("FAIL store%0d_wmask: got %b want %b", i, mem_wmask, exp_mask[i]); end
      n_chk++; if (mem_wdata !== exp_data[i]) begin n_fail++; $display("FAIL store%0d_wdata: got %h want %h", i, mem_wdata, exp_data[i]); end
      n_chk++; if (dm_valid !== 1'b0) begin n_fail++; $display("FAIL store%0d_early_valid: got %b want 0", i, dm_valid); end
      mem_gnt = 1'b1;
      #1;
      n_chk++; if (dm_valid !== 1'b1 || dm_err !== 1'b0) begin n_fail++; $display("FAIL store%0d_valid: got %b err %b want 1 err 0", i, dm_valid, dm_err); end
      @(posedge clk); #1;
      mem_gnt = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      #1;
      n_chk++; if (dm_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL store%0d_after: valid %b req %b want 0/0", i, dm_valid, mem_req); end
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] a [5];
    logic [1:0]  s [5];
    logic        u [5];
    logic [31:0] rd [5];
    logic [31:0] ex [5];
    logic [31:0] maddr, data;
    logic        v, err;
    a[0] = 32'h12; s[0] = MS_HALF; u[0] = 1'b0; rd[0] = 32'h80011234; ex[0] = 32'hFFFF8001;
    a[1] = 32'h12; s[1] = MS_HALF; u[1] = 1'b1; rd[1] = 32'h80011234; ex[1] = 32'h00008001;
    a[2] = 32'h31; s[2] = MS_BYTE; u[2] = 1'b0; rd[2] = 32'h00008000; ex[2] = 32'hFFFFFF80;
    a[3] = 32'h33; s[3] = MS_BYTE; u[3] = 1'b1; rd[3] = 32'hF0000000; ex[3] = 32'h000000F0;
    a[4] = 32'h40; s[4] = MS_WORD; u[4] = 1'b0; rd[4] = 32'h87654321; ex[4] = 32'h87654321;
    for (int i = 0; i < 5; i++) begin
      dm_load(a[i], s[i], u[i], rd[i], maddr, v, data, err);
      n_chk++; if (maddr !== {a[i][31:2], 2'b00}) begin n_fail++; $display("FAIL load%0d_addr: got %h want %h", i, maddr, {a[i][31:2], 2'b00}); end
      n_chk++; if (v !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL load%0d_valid: got %b err %b want 1 err 0", i, v, err); end
      n_chk++; if (data !== ex[i]) begin n_fail++; $display("FAIL load%0d_rdata: got %h want %h", i, data, ex[i]); end
    end
  endtask

  task automatic test_contention();
    logic exp_dm;
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = MS_WORD; dm_unsigned = 1'b0; dm_addr = 32'h800;
    for (int i = 0; i < 4; i++) begin
      exp_dm = (i % 2 == 0);
      @(posedge clk); #1;
      n_chk++; if (mem_addr !== (exp_dm ? 32'h800 : 32'h400)) begin n_fail++; $display("FAIL contend%0d_owner_addr: got %h want %h", i, mem_addr, exp_dm ? 32'h800 : 32'h400); end
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h100 + i;
      #1;
      n_chk++; if ({dm_valid, if_valid} !== {exp_dm, ~exp_dm}) begin n_fail++; $display("FAIL contend%0d_valids: got dm %b if %b want dm %b if %b", i, dm_valid, if_valid, exp_dm, ~exp_dm); end
      n_chk++; if ((exp_dm ? dm_rdata : if_rdata) !== 32'h100 + i) begin n_fail++; $display("FAIL contend%0d_rdata: got %h want %h", i, exp_dm ? dm_rdata : if_rdata, 32'h100 + i); end
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h500;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    n_chk++; if (dut.state_q !== RSP) begin n_fail++; $display("FAIL rstmid_in_rsp: state got %0d want %0d", dut.state_q, RSP); end
    rst_n = 1'b0;
    #1;
    if_req = 1'b0;
    n_chk++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear: req %b valid %b want 0/0", mem_req, if_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    n_chk++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_rvalid: if %b dm %b want 0/0", if_valid, dm_valid); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    n_chk++; if (dut.state_q !== IDLE || mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: state %0d req %b want %0d/0", dut.state_q, mem_req, IDLE); end
  endtask

  task automatic test_misaligned();
    dm_req = 1'b1; dm_we = 1'b0; dm_size = MS_WORD; dm_unsigned = 1'b0; dm_addr = 32'h6;
    @(posedge clk); #1;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL misalign_mem_req: got %b want 0", mem_req); end
    n_chk++; if (dm_valid !== 1'b1 || dm_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err_pulse: valid %b err %b want 1/1", dm_valid, dm_err); end
    n_chk++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL misalign_rdata: got %h want 0", dm_rdata); end
    dm_req = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (dm_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL misalign_after: valid %b req %b want 0/0", dm_valid, mem_req); end
`else
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL misalign_word_addr: req %b addr %h want 1/00000004", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    #1;
    n_chk++; if (dm_valid !== 1'b1 || dm_err !== 1'b0) begin n_fail++; $display("FAIL misalign_valid_err: valid %b err %b want 1/0", dm_valid, dm_err); end
    n_chk++; if (dm_rdata !== 32'h11223344) begin n_fail++; $display("FAIL misalign_rdata: got %h want 11223344", dm_rdata); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0; dm_req = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store();
    test_load_ext();
    test_contention();
    test_reset_mid();
    test_misaligned();
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
